rr_arb_4b_5to1: RTL

Round-robin arbiter and single-entry output register that feeds the 4-bit 5-to-1 combinational mux stage. It accepts five 4-bit valid/ready input channels and picks one per cycle with fair rotating priority. It drives the 3-bit select (encoding 0–4, same as the mux), captures the selected data, and presents it on a registered valid/ready output channel.

---
 rtl/rr_arb_4b_5to1.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_arb_4b_5to1.sv
// Five-channel 4-bit round-robin arbiter with a single-entry registered output.
// Priority rotates to the channel after the winner, only on accepted transfers.
module rr_arb_4b_5to1 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  input  logic [4:0] in_val,
  output logic [4:0] in_rdy,
  output logic [3:0] out,
  output logic [2:0] out_sel,
  output logic       out_val,
  input  logic       out_rdy
);

  logic [2:0] ptr_q, ptr_d;
  logic       full_q, full_d;
  logic [3:0] data_q, data_d;
  logic [2:0] sel_q, sel_d;

  logic       gnt_vld;
  logic [2:0] gnt;
  logic [3:0] gnt_data;
  logic       can_accept;
  logic       xfer;
  logic [3:0] sum;
  logic [2:0] idx;

  // Scan from the farthest offset down so the closest valid channel to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 3'd0;
    sum     = 4'd0;
    idx     = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + 4'(i);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (in_val[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    case (gnt)
      3'd0:    gnt_data = in0;
      3'd1:    gnt_data = in1;
      3'd2:    gnt_data = in2;
      3'd3:    gnt_data = in3;
      default: gnt_data = in4;
    endcase
  end

  assign can_accept = !full_q || out_rdy;
  assign xfer       = gnt_vld && can_accept;
  assign in_rdy     = xfer ? 5'(5'b00001 << gnt) : 5'b00000;

  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (xfer) begin
      data_d = gnt_data;
      sel_d  = gnt;
      full_d = 1'b1;
      ptr_d  = (gnt == 3'd4) ? 3'd0 : gnt + 3'd1;
    end else if (full_q && out_rdy) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= 3'd0;
      full_q <= 1'b0;
      data_q <= 4'd0;
      sel_q  <= 3'd0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign out_val = full_q;
  assign out     = data_q;
  assign out_sel = sel_q;

endmodule
